tree_router_node: RTL and testbench
===================================

Name: tree_router_node

Overview:
- Three-port packet router node for the binary-tree network-on-chip: one parent port (P) and two child ports (C1, C2), each with an input and an output stream.
- Each incoming packet's destination field is compared against this node's address under a mask.
- The packet is forwarded up to the parent or down to one child.
- Per-output one-entry registered buffers; round-robin arbitration among inputs competing for the same output.

Parameters:
- WIDTH, 47, packet width. Format: [46] ifmap/filter select, [45:43] destination, [42:40] source, [39:0] data.
- ADDR_WIDTH, 3, destination field width.
- DEST_LSB, 43, bit index of destination LSB within the packet.
- ADDRESS, 3'b100, this node's address.
- MASK, 3'b110, bits of ADDRESS compared for up-routing.
- SEL_BIT, 0, destination bit that selects the child on down-routing.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- c1_in_valid / c1_in_ready / c1_in_data  in/out/in  1/1/WIDTH  child-1 input stream
- c2_in_valid / c2_in_ready / c2_in_data  in/out/in  1/1/WIDTH  child-2 input stream
- p_in_valid / p_in_ready / p_in_data  in/out/in  1/1/WIDTH  parent input stream
- c1_out_valid / c1_out_ready / c1_out_data  out/in/out  1/1/WIDTH  child-1 output stream
- c2_out_valid / c2_out_ready / c2_out_data  out/in/out  1/1/WIDTH  child-2 output stream
- p_out_valid / p_out_ready / p_out_data  out/in/out  1/1/WIDTH  parent output stream

Behaviour:
- Handshake: a transfer occurs on a rising edge when valid && ready.
  - A sender holds valid and data stable until the transfer.
  - valid never depends on ready.
- Route decode, with dest = data[DEST_LSB+ADDR_WIDTH-1:DEST_LSB]:
  - UP when (dest & MASK) == (ADDRESS & MASK), go to P output.
  - Otherwise DOWN: dest[SEL_BIT]==0 goes to C1, ==1 goes to C2.
  - The rule applies regardless of source port. Hairpin (C1 to C1, P to P) is legal and forwarded.
- Output buffer: each output has one register (valid + data).
  - It can load when empty or when being drained in the same cycle (out_valid && out_ready), giving full throughput.
- Arbitration: per output, the requesters are the valid inputs decoding to it.
  - Round-robin order C1, C2, P; the pointer advances past the winner after each grant.
  - in_ready for an input is asserted only when it is the grantee of its target output and that output can load.
  - in_ready may depend combinationally on in_valid/in_data of all inputs and on out_ready.
- Latency: packet accepted on edge N appears on out_valid/out_data after edge N and stays until out_ready.
- Disjoint routes transfer in parallel: up to three packets per cycle.
- Packets are never modified, dropped or duplicated. Order is preserved per input-output pair.
- Reset (asynchronous, rst_n low):
  - All out_valid = 0, out_data = 0.
  - All arbitration pointers favour C1.
  - All in_ready = 0 while reset is asserted.
  - Reset mid-transfer discards buffered packets.
  - After deassertion, operation resumes on the next edge.
- Stall: out_ready low holds out_valid/out_data. Inputs targeting that output see in_ready low; other inputs proceed.

Optional Feature:
- ROUTER_STATS_EN defined adds three 16-bit outputs p_fwd_count, c1_fwd_count, c2_fwd_count.
  - Each increments on every completed output transfer on its port.
  - Each wraps from 16'hFFFF to 0 and resets to 0.
- ROUTER_STATS_EN undefined: the ports and counters do not exist. Routing behaviour is identical.

Test Plan:
- C1 sends packet with dest=3'b100, all other outputs ready → appears on p_out one cycle later; c1_out/c2_out stay invalid.
- C2 sends dest=3'b100 → p_out. C1 sends dest=3'b001 → c2_out. C2 sends dest=3'b010 → c1_out. Data bits [46] and [42:0] unchanged.
- P sends dest=3'b001 → c2_out; P sends dest=3'b110 → c1_out.
- Contention: C1 and C2 both send dest=3'b100 in the same cycle, held continuously → p_out order C1, C2, C1, C2 (round-robin); each gets one transfer per two cycles.
- Backpressure: p_out_ready low for 5 cycles with C1 sending dest=3'b100 → p_out_valid held with stable data, c1_in_ready low. Concurrently, P to C2 (dest=3'b001) still transfers every cycle.
- Reset asserted while c2_out holds a packet → c2_out_valid drops immediately (asynchronous). After release, a fresh C1→C2 packet routes correctly. With ROUTER_STATS_EN, counters read 0 after reset.

Source files
------------

// File: rtl/tree_router_node.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tree_router_node                                                |
// | Purpose  : 3-port binary-tree NoC router node (parent + two children),     |
// |            one-entry output buffers, per-output round-robin arbitration.   |
// | Options  : ROUTER_STATS_EN adds per-output 16-bit forwarded-packet counts. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tree_router_node #(
  parameter int                    WIDTH      = 47,
  parameter int                    ADDR_WIDTH = 3,
  parameter int                    DEST_LSB   = 43,
  parameter logic [ADDR_WIDTH-1:0] ADDRESS    = 3'b100,
  parameter logic [ADDR_WIDTH-1:0] MASK       = 3'b110,
  parameter int                    SEL_BIT    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             c1_in_valid,
  output logic             c1_in_ready,
  input  logic [WIDTH-1:0] c1_in_data,
  input  logic             c2_in_valid,
  output logic             c2_in_ready,
  input  logic [WIDTH-1:0] c2_in_data,
  input  logic             p_in_valid,
  output logic             p_in_ready,
  input  logic [WIDTH-1:0] p_in_data,
  output logic             c1_out_valid,
  input  logic             c1_out_ready,
  output logic [WIDTH-1:0] c1_out_data,
  output logic             c2_out_valid,
  input  logic             c2_out_ready,
  output logic [WIDTH-1:0] c2_out_data,
  output logic             p_out_valid,
  input  logic             p_out_ready,
  output logic [WIDTH-1:0] p_out_data
`ifdef ROUTER_STATS_EN
  ,
  output logic [15:0]      p_fwd_count,
  output logic [15:0]      c1_fwd_count,
  output logic [15:0]      c2_fwd_count
`endif
);

  // Port index used for both inputs and outputs; also the round-robin order.
  localparam int c_C1 = 0;
  localparam int c_C2 = 1;
  localparam int c_P  = 2;

  logic [2:0]            w_in_valid;
  logic [2:0][WIDTH-1:0] w_in_data;
  logic [2:0]            w_in_ready;
  logic [2:0]            w_out_ready;
  logic [2:0][2:0]       w_route;      // [input][output] one-hot target
  logic [2:0][2:0]       w_req;        // [output][input]
  logic [2:0][2:0]       w_grant;      // [output][input]
  logic [2:0]            w_can_load;
  logic [2:0]            w_accept;
  logic [2:0][WIDTH-1:0] w_load_data;
  logic [2:0]            w_buf_valid;
  logic [2:0][WIDTH-1:0] w_buf_data;
  logic [2:0][1:0]       w_ptr;

  assign w_in_valid  = {p_in_valid, c2_in_valid, c1_in_valid};
  assign w_in_data   = {p_in_data, c2_in_data, c1_in_data};
  assign w_out_ready = {p_out_ready, c2_out_ready, c1_out_ready};

  // First requester at or after the pointer, wrapping C1 -> C2 -> P.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [2:0] g;
    g = '0;
    case (ptr)
      2'd1: begin
        if (req[1])      g = 3'b010;
        else if (req[2]) g = 3'b100;
        else if (req[0]) g = 3'b001;
      end
      2'd2: begin
        if (req[2])      g = 3'b100;
        else if (req[0]) g = 3'b001;
        else if (req[1]) g = 3'b010;
      end
      default: begin
        if (req[0])      g = 3'b001;
        else if (req[1]) g = 3'b010;
        else if (req[2]) g = 3'b100;
      end
    endcase
    return g;
  endfunction

  function automatic logic [1:0] rr_next(input logic [2:0] grant);
    logic [1:0] p;
    case (grant)
      3'b001:  p = 2'd1;
      3'b010:  p = 2'd2;
      default: p = 2'd0;
    endcase
    return p;
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g_dec
    logic [ADDR_WIDTH-1:0] w_dest;
    logic                  w_up;
    assign w_dest          = w_in_data[i][DEST_LSB +: ADDR_WIDTH];
    assign w_up            = ((w_dest & MASK) == (ADDRESS & MASK));
    assign w_route[i][c_P]  = w_up;
    assign w_route[i][c_C2] = ~w_up & w_dest[SEL_BIT];
    assign w_route[i][c_C1] = ~w_up & ~w_dest[SEL_BIT];
  end

  always_comb begin
    w_req       = '0;
    w_grant     = '0;
    w_can_load  = '0;
    w_accept    = '0;
    w_load_data = '0;
    for (int o = 0; o < 3; o++) begin
      for (int i = 0; i < 3; i++) begin
        w_req[o][i] = w_in_valid[i] & w_route[i][o];
      end
      // A full buffer that drains this cycle can take a new packet.
      w_can_load[o] = ~w_buf_valid[o] | w_out_ready[o];
      w_grant[o]    = rr_pick(w_req[o], w_ptr[o]);
      w_accept[o]   = w_can_load[o] & (|w_grant[o]);
      for (int i = 0; i < 3; i++) begin
        if (w_grant[o][i]) w_load_data[o] = w_in_data[i];
      end
    end
  end

  always_comb begin
    w_in_ready = '0;
    for (int i = 0; i < 3; i++) begin
      w_in_ready[i] = rst_n & ((w_grant[c_C1][i] & w_can_load[c_C1]) |
                               (w_grant[c_C2][i] & w_can_load[c_C2]) |
                               (w_grant[c_P][i]  & w_can_load[c_P]));
    end
  end

  assign c1_in_ready = w_in_ready[c_C1];
  assign c2_in_ready = w_in_ready[c_C2];
  assign p_in_ready  = w_in_ready[c_P];

  for (genvar o = 0; o < 3; o++) begin : g_out
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [1:0]       r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_ptr   <= 2'd0;
      end else if (w_accept[o]) begin
        r_valid <= 1'b1;
        r_data  <= w_load_data[o];
        r_ptr   <= rr_next(w_grant[o]);
      end else if (w_out_ready[o]) begin
        r_valid <= 1'b0;
      end
    end

    assign w_buf_valid[o] = r_valid;
    assign w_buf_data[o]  = r_data;
    assign w_ptr[o]       = r_ptr;
  end

  assign c1_out_valid = w_buf_valid[c_C1];
  assign c1_out_data  = w_buf_data[c_C1];
  assign c2_out_valid = w_buf_valid[c_C2];
  assign c2_out_data  = w_buf_data[c_C2];
  assign p_out_valid  = w_buf_valid[c_P];
  assign p_out_data   = w_buf_data[c_P];

`ifdef ROUTER_STATS_EN
  logic [2:0][15:0] w_count;

  for (genvar o = 0; o < 3; o++) begin : g_stats
    logic [15:0] r_count;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_count <= 16'd0;
      end else if (w_buf_valid[o] && w_out_ready[o]) begin
        r_count <= r_count + 16'd1;
      end
    end
    assign w_count[o] = r_count;
  end

  assign c1_fwd_count = w_count[c_C1];
  assign c2_fwd_count = w_count[c_C2];
  assign p_fwd_count  = w_count[c_P];
`endif

endmodule
`default_nettype wire

// File: tb/tb_tree_router_node.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tree_router_node                                             |
// | Purpose  : Directed self-checking bench for tree_router_node (ADDRESS=100, |
// |            MASK=110, SEL_BIT=0). Honours ROUTER_STATS_EN when defined.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_tree_router_node;
  localparam int c_W = 47;

  logic           clk;
  logic           rst_n;
  logic           c1_in_valid, c2_in_valid, p_in_valid;
  logic           c1_in_ready, c2_in_ready, p_in_ready;
  logic [c_W-1:0] c1_in_data, c2_in_data, p_in_data;
  logic           c1_out_valid, c2_out_valid, p_out_valid;
  logic           c1_out_ready, c2_out_ready, p_out_ready;
  logic [c_W-1:0] c1_out_data, c2_out_data, p_out_data;
`ifdef ROUTER_STATS_EN
  logic [15:0]    p_fwd_count, c1_fwd_count, c2_fwd_count;
`endif

  int n_cmp;
  int n_err;

  tree_router_node dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .c1_in_valid  (c1_in_valid),
    .c1_in_ready  (c1_in_ready),
    .c1_in_data   (c1_in_data),
    .c2_in_valid  (c2_in_valid),
    .c2_in_ready  (c2_in_ready),
    .c2_in_data   (c2_in_data),
    .p_in_valid   (p_in_valid),
    .p_in_ready   (p_in_ready),
    .p_in_data    (p_in_data),
    .c1_out_valid (c1_out_valid),
    .c1_out_ready (c1_out_ready),
    .c1_out_data  (c1_out_data),
    .c2_out_valid (c2_out_valid),
    .c2_out_ready (c2_out_ready),
    .c2_out_data  (c2_out_data),
    .p_out_valid  (p_out_valid),
    .p_out_ready  (p_out_ready),
    .p_out_data   (p_out_data)
`ifdef ROUTER_STATS_EN
    ,
    .p_fwd_count  (p_fwd_count),
    .c1_fwd_count (c1_fwd_count),
    .c2_fwd_count (c2_fwd_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  function automatic logic [c_W-1:0] pkt(input logic sel, input logic [2:0] dest,
                                         input logic [2:0] src, input logic [39:0] data);
    return {sel, dest, src, data};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Port index: 0 = C1, 1 = C2, 2 = P.
  task automatic drive(input int port, input logic v, input logic [c_W-1:0] d);
    case (port)
      0:       begin c1_in_valid = v; c1_in_data = d; end
      1:       begin c2_in_valid = v; c2_in_data = d; end
      default: begin p_in_valid  = v; p_in_data  = d; end
    endcase
  endtask

  function automatic logic in_rdy(input int port);
    case (port)
      0:       return c1_in_ready;
      1:       return c2_in_ready;
      default: return p_in_ready;
    endcase
  endfunction

  function automatic logic out_vld(input int port);
    case (port)
      0:       return c1_out_valid;
      1:       return c2_out_valid;
      default: return p_out_valid;
    endcase
  endfunction

  function automatic logic [c_W-1:0] out_dat(input int port);
    case (port)
      0:       return c1_out_data;
      1:       return c2_out_data;
      default: return p_out_data;
    endcase
  endfunction

  // One packet from src to dst with every output ready; called at posedge+1.
  task automatic send_one(input string tag, input int src, input logic [c_W-1:0] d, input int dst);
    drive(src, 1'b1, d);
    #1;
    chk({tag, "_rdy"}, 64'(in_rdy(src)), 64'd1);
    @(posedge clk); #1;
    drive(src, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_v%0d", tag, k), 64'(out_vld(k)), (k == dst) ? 64'd1 : 64'd0);
    end
    chk({tag, "_dat"}, 64'(out_dat(dst)), 64'(d));
  endtask

  logic [c_W-1:0] c1_pk [4];
  logic [c_W-1:0] c2_pk [4];
  logic [c_W-1:0] pk_b, pk_b2, pk_r, pk_f;
  logic [c_W-1:0] p_stream [7];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    c1_in_valid = 1'b0; c1_in_data = '0;
    c2_in_valid = 1'b0; c2_in_data = '0;
    p_in_valid  = 1'b0; p_in_data  = '0;
    c1_out_ready = 1'b1; c2_out_ready = 1'b1; p_out_ready = 1'b1;

    // Reset state, including in_ready held low despite a valid request.
    repeat (2) @(posedge clk);
    #1;
    drive(0, 1'b1, pkt(1'b0, 3'b100, 3'b001, 40'h1));
    #1;
    chk("rst_c1_rdy", 64'(c1_in_ready), 64'd0);
    chk("rst_p_v",    64'(p_out_valid), 64'd0);
    chk("rst_c1_v",   64'(c1_out_valid), 64'd0);
    chk("rst_c2_v",   64'(c2_out_valid), 64'd0);
    chk("rst_p_d",    64'(p_out_data), 64'd0);
    drive(0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Route decode from every source.
    send_one("c1_p",  0, pkt(1'b1, 3'b100, 3'b011, 40'hA5A5_0000_01), 2);
    send_one("c2_p",  1, pkt(1'b0, 3'b100, 3'b101, 40'h0123_4567_89), 2);
    send_one("c1_c2", 0, pkt(1'b1, 3'b001, 3'b111, 40'hFFFF_FFFF_FF), 1);
    send_one("c2_c1", 1, pkt(1'b0, 3'b010, 3'b000, 40'h8000_0000_01), 0);
    send_one("p_c2",  2, pkt(1'b1, 3'b001, 3'b100, 40'hDEAD_BEEF_00), 1);
    send_one("p_c1",  2, pkt(1'b0, 3'b110, 3'b010, 40'h0000_0000_00), 0);
    send_one("p_p",   2, pkt(1'b1, 3'b101, 3'b110, 40'h5A5A_5A5A_5A), 2);
    send_one("c1_c1", 0, pkt(1'b0, 3'b000, 3'b001, 40'h3C3C_3C3C_3C), 0);

    // Contention for P: C1 and C2 held valid; pointer favours C1 here.
    for (int k = 0; k < 4; k++) begin
      c1_pk[k] = pkt(1'b0, 3'b100, 3'b001, 40'h1100 + 40'(k));
      c2_pk[k] = pkt(1'b1, 3'b100, 3'b010, 40'h2200 + 40'(k));
    end
    drive(0, 1'b1, c1_pk[0]);
    drive(1, 1'b1, c2_pk[0]);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("arb%0d_c1_rdy", k), 64'(c1_in_ready), (k % 2 == 0) ? 64'd1 : 64'd0);
      chk($sformatf("arb%0d_c2_rdy", k), 64'(c2_in_ready), (k % 2 == 1) ? 64'd1 : 64'd0);
      @(posedge clk); #1;
      if (k % 2 == 0) begin
        chk($sformatf("arb%0d_dat", k), 64'(p_out_data), 64'(c1_pk[k/2]));
        drive(0, 1'b1, c1_pk[k/2 + 1]);
      end else begin
        chk($sformatf("arb%0d_dat", k), 64'(p_out_data), 64'(c2_pk[k/2]));
        drive(1, 1'b1, c2_pk[k/2 + 1]);
      end
    end
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    @(posedge clk); #1;
    chk("arb_drain", 64'(p_out_valid), 64'd0);

    // Backpressure on P while P->C2 keeps streaming.
    pk_b  = pkt(1'b1, 3'b100, 3'b001, 40'hB0B0_0000_01);
    pk_b2 = pkt(1'b1, 3'b100, 3'b001, 40'hB0B0_0000_02);
    for (int j = 0; j < 7; j++) p_stream[j] = pkt(1'b0, 3'b001, 3'b100, 40'hC0DE_0000_00 + 40'(j));
    drive(0, 1'b1, pk_b);
    drive(2, 1'b1, p_stream[0]);
    #1;
    chk("bp_c1_rdy0", 64'(c1_in_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp_p_dat0", 64'(p_out_data), 64'(pk_b));
    p_out_ready = 1'b0;
    drive(0, 1'b1, pk_b2);
    drive(2, 1'b1, p_stream[1]);
    for (int j = 0; j < 5; j++) begin
      #1;
      chk($sformatf("bp%0d_c1_rdy", j), 64'(c1_in_ready), 64'd0);
      chk($sformatf("bp%0d_p_rdy", j),  64'(p_in_ready), 64'd1);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_p_v", j),    64'(p_out_valid), 64'd1);
      chk($sformatf("bp%0d_p_dat", j),  64'(p_out_data), 64'(pk_b));
      chk($sformatf("bp%0d_c2_dat", j), 64'(c2_out_data), 64'(p_stream[j+1]));
      drive(2, 1'b1, p_stream[j+2]);
    end
    drive(2, 1'b0, '0);
    p_out_ready = 1'b1;
    #1;
    chk("bp_c1_rdy_rel", 64'(c1_in_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp_p_dat_rel", 64'(p_out_data), 64'(pk_b2));
    drive(0, 1'b0, '0);
    @(posedge clk); #1;

    // Asynchronous reset while C2 output holds a packet.
    pk_r = pkt(1'b0, 3'b001, 3'b001, 40'h7777_7777_77);
    c2_out_ready = 1'b0;
    drive(0, 1'b1, pk_r);
    @(posedge clk); #1;
    drive(0, 1'b0, '0);
    chk("rr_hold_v", 64'(c2_out_valid), 64'd1);
    chk("rr_hold_d", 64'(c2_out_data), 64'(pk_r));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_async_v", 64'(c2_out_valid), 64'd0);
    chk("rr_async_d", 64'(c2_out_data), 64'd0);
`ifdef ROUTER_STATS_EN
    chk("rr_cnt_p",  64'(p_fwd_count),  64'd0);
    chk("rr_cnt_c1", 64'(c1_fwd_count), 64'd0);
    chk("rr_cnt_c2", 64'(c2_fwd_count), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    c2_out_ready = 1'b1;
    @(posedge clk); #1;
    pk_f = pkt(1'b1, 3'b011, 3'b001, 40'h0F0F_0F0F_0F);
    send_one("post_rst", 0, pk_f, 1);
    @(posedge clk); #1;
    chk("post_drain", 64'(c2_out_valid), 64'd0);
`ifdef ROUTER_STATS_EN
    chk("post_cnt_c2", 64'(c2_fwd_count), 64'd1);
    chk("post_cnt_p",  64'(p_fwd_count),  64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
